// File: rtl/miner_pkg.sv
// Shared widths and default constants for the nonce/work control slice.
package miner_pkg;

  localparam int          NONCE_W              = 32;
  localparam int          MIDSTATE_W           = 256;
  localparam int          DATA_W               = 96;
  localparam logic [31:0] DEFAULT_TARGET       = 32'hA41F32E7;
  localparam int          DEFAULT_PIPE_LATENCY = 254;
  localparam int          DROP_CNT_W           = 16;

endpackage

// File: rtl/golden_fifo.sv
// First-word-fall-through synchronous FIFO for golden nonces.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module golden_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // The extra pointer bit tells full apart from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/nonce_ctrl_multi.sv
// Nonce/work control for NUM_CORES interleaved SHA-256d hashers with golden-nonce FIFO.
// Optional GOLDEN_DROP_CNT_EN adds a saturating drop_count output.
module nonce_ctrl_multi
  import miner_pkg::*;
#(
  parameter int          NUM_CORES    = 4,
  parameter int          PIPE_LATENCY = DEFAULT_PIPE_LATENCY,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TARGET       = DEFAULT_TARGET
) (
  input  logic                    hash_clk,
  input  logic                    hash_rst_n,
  input  logic [MIDSTATE_W-1:0]   work_midstate,
  input  logic [DATA_W-1:0]       work_data,
  output logic [MIDSTATE_W-1:0]   hasher_midstate,
  output logic [DATA_W-1:0]       hasher_data,
  output logic [NONCE_W-1:0]      hasher_nonce,
  input  logic [NUM_CORES*32-1:0] hash2_w,
  output logic                    golden_valid,
  output logic [NONCE_W-1:0]      golden_nonce,
  input  logic                    golden_ready,
  output logic                    hashing,
  output logic                    fifo_overflow
`ifdef GOLDEN_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]   drop_count
`endif
);

  localparam int          CNT_W     = $clog2(NUM_CORES + 1);
  localparam int          IGN_W     = $clog2(PIPE_LATENCY + 2);
  localparam logic [31:0] STEP      = 32'(NUM_CORES);
  localparam logic [31:0] LEAD      = 32'(PIPE_LATENCY * NUM_CORES);
  localparam logic [31:0] LANE_MASK = ~(STEP - 32'd1);

  logic              new_work;
  logic              cont;
  logic [31:0]       rpt_base;
  logic [31:0]       stop_base;
  logic [IGN_W-1:0]  ign_cnt;
  logic [CNT_W-1:0]  hit_cnt;
  logic [31:0]       first_nonce;
  logic              hit_r;
  logic [31:0]       hit_nonce;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              full_drop;
  logic              multi_drop;

  assign cont         = (rpt_base != stop_base) || new_work;
  assign golden_valid = !fifo_empty;
  assign pop          = golden_valid && golden_ready;
  assign full_drop    = hit_r && fifo_full && !pop;
  assign multi_drop   = (hit_cnt > CNT_W'(1));

  // Descending scan so the lowest hitting core ends up owning first_nonce.
  always_comb begin
    hit_cnt     = '0;
    first_nonce = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if ((hash2_w[32*k +: 32] == TARGET) && cont && (ign_cnt == '0)) begin
        hit_cnt     = hit_cnt + CNT_W'(1);
        first_nonce = (rpt_base & LANE_MASK) | 32'(k);
      end
    end
  end

  always_ff @(posedge hash_clk or negedge hash_rst_n) begin
    if (!hash_rst_n) begin
      hasher_midstate <= '0;
      hasher_data     <= '0;
      new_work        <= 1'b0;
      hasher_nonce    <= '0;
      hashing         <= 1'b0;
      rpt_base        <= '0;
      stop_base       <= '0;
      ign_cnt         <= '0;
      hit_r           <= 1'b0;
      hit_nonce       <= '0;
      fifo_overflow   <= 1'b0;
    end else begin
      hasher_midstate <= work_midstate;
      hasher_data     <= work_data;
      new_work        <= (hasher_midstate != work_midstate) || (hasher_data != work_data);
      hasher_nonce    <= rpt_base + LEAD;
      hashing         <= cont;
      if (cont) rpt_base <= rpt_base + STEP;
      // A full sweep ends when rpt_base wraps back onto the value it had at new work.
      if (new_work) stop_base <= rpt_base;
      if (new_work)
        ign_cnt <= IGN_W'(PIPE_LATENCY);
      else if (ign_cnt != '0)
        ign_cnt <= ign_cnt - IGN_W'(1);
      hit_r     <= (hit_cnt != '0);
      hit_nonce <= first_nonce;
      if (multi_drop || full_drop) fifo_overflow <= 1'b1;
    end
  end

  golden_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_fifo (
    .clk   (hash_clk),
    .rst_n (hash_rst_n),
    .push  (hit_r),
    .din   (hit_nonce),
    .pop   (pop),
    .dout  (golden_nonce),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef GOLDEN_DROP_CNT_EN
  logic [CNT_W:0]      drop_inc;
  logic [DROP_CNT_W:0] drop_sum;

  // Each extra same-cycle hit and each push refused by a full FIFO counts once.
  assign drop_inc = ((hit_cnt != '0) ? {1'b0, hit_cnt - CNT_W'(1)} : '0) + (CNT_W+1)'(full_drop);
  assign drop_sum = {1'b0, drop_count} + (DROP_CNT_W+1)'(drop_inc);

  always_ff @(posedge hash_clk or negedge hash_rst_n) begin
    if (!hash_rst_n)
      drop_count <= '0;
    else
      drop_count <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_nonce_ctrl_multi.sv
// Self-checking bench for nonce_ctrl_multi (NUM_CORES=4, PIPE_LATENCY=4, FIFO_DEPTH=8).
// Builds with or without GOLDEN_DROP_CNT_EN.
module tb_nonce_ctrl_multi;

  localparam int          NC  = 4;
  localparam int          PL  = 4;
  localparam int          FD  = 8;
  localparam logic [31:0] TGT = 32'hA41F32E7;

  logic            hash_clk = 1'b0;
  logic            hash_rst_n = 1'b0;
  logic [255:0]    work_midstate = '0;
  logic [95:0]     work_data = '0;
  logic [255:0]    hasher_midstate;
  logic [95:0]     hasher_data;
  logic [31:0]     hasher_nonce;
  logic [NC*32-1:0] hash2_w = '0;
  logic            golden_valid;
  logic [31:0]     golden_nonce;
  logic            golden_ready = 1'b0;
  logic            hashing;
  logic            fifo_overflow;
`ifdef GOLDEN_DROP_CNT_EN
  logic [15:0]     drop_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 hash_clk = ~hash_clk;

  nonce_ctrl_multi #(
    .NUM_CORES    (NC),
    .PIPE_LATENCY (PL),
    .FIFO_DEPTH   (FD),
    .TARGET       (TGT)
  ) dut (
    .hash_clk        (hash_clk),
    .hash_rst_n      (hash_rst_n),
    .work_midstate   (work_midstate),
    .work_data       (work_data),
    .hasher_midstate (hasher_midstate),
    .hasher_data     (hasher_data),
    .hasher_nonce    (hasher_nonce),
    .hash2_w         (hash2_w),
    .golden_valid    (golden_valid),
    .golden_nonce    (golden_nonce),
    .golden_ready    (golden_ready),
    .hashing         (hashing),
    .fifo_overflow   (fifo_overflow)
`ifdef GOLDEN_DROP_CNT_EN
    ,
    .drop_count      (drop_count)
`endif
  );

  // Behavioural model: work copy, nonce counters, ignore window, and a queue for the FIFO.
  logic [255:0] m_mid;
  logic [95:0]  m_data;
  bit           m_nw;
  logic [31:0]  m_rpt, m_stop, m_nonce;
  bit           m_hashing;
  int           m_ign;
  bit           m_pend;
  logic [31:0]  m_pend_nonce;
  logic [31:0]  m_q[$];
  bit           m_ovf;
  int           m_drop;
  bit           mc;
  int           mnh, mfirst, minc;

  always @(posedge hash_clk or negedge hash_rst_n) begin
    if (!hash_rst_n) begin
      m_mid = '0; m_data = '0; m_nw = 0; m_rpt = '0; m_stop = '0; m_nonce = '0;
      m_hashing = 0; m_ign = 0; m_pend = 0; m_pend_nonce = '0; m_ovf = 0; m_drop = 0;
      m_q.delete();
    end else begin
      mc = (m_rpt != m_stop) || m_nw;
      mnh = 0; mfirst = -1; minc = 0;
      for (int k = 0; k < NC; k++) begin
        if (hash2_w[32*k +: 32] == TGT && mc && m_ign == 0) begin
          mnh++;
          if (mfirst < 0) mfirst = k;
        end
      end
      if (m_q.size() != 0 && golden_ready) void'(m_q.pop_front());
      if (m_pend) begin
        if (m_q.size() < FD) m_q.push_back(m_pend_nonce);
        else begin m_ovf = 1; minc++; end
      end
      if (mnh > 1) begin m_ovf = 1; minc += mnh - 1; end
      m_pend = (mnh > 0);
      if (mnh > 0) m_pend_nonce = m_rpt - (m_rpt % NC) + 32'(mfirst);
      m_drop = (m_drop + minc > 65535) ? 65535 : m_drop + minc;
      m_nonce = m_rpt + 32'(PL * NC);
      m_hashing = mc;
      if (m_nw) m_ign = PL; else if (m_ign > 0) m_ign--;
      if (m_nw) m_stop = m_rpt;
      if (mc) m_rpt = m_rpt + 32'(NC);
      m_nw = (m_mid != work_midstate) || (m_data != work_data);
      m_mid = work_midstate;
      m_data = work_data;
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  always @(negedge hash_clk) begin
    if (hash_rst_n) begin
      checkOutput("midstate", hasher_midstate, m_mid);
      checkOutput("data", hasher_data, m_data);
      checkOutput("nonce", hasher_nonce, m_nonce);
      checkOutput("hashing", hashing, m_hashing);
      checkOutput("valid", golden_valid, m_q.size() != 0);
      if (m_q.size() != 0) checkOutput("golden_nonce", golden_nonce, m_q[0]);
      checkOutput("overflow", fifo_overflow, m_ovf);
`ifdef GOLDEN_DROP_CNT_EN
      checkOutput("drop_count", drop_count, 256'(m_drop));
`endif
    end
  end

  task automatic tick();
    @(posedge hash_clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [NC-1:0] mask);
    for (int k = 0; k < NC; k++) hash2_w[32*k +: 32] = mask[k] ? TGT : 32'h0;
  endtask

  task automatic waitRpt(input logic [31:0] target);
    for (int i = 0; i < 2000 && m_rpt != target; i++) tick();
    if (m_rpt != target) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_rpt: got %0h expected %0h", m_rpt, target);
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_midstate"}, hasher_midstate, '0);
    checkOutput({tag, "_data"}, hasher_data, '0);
    checkOutput({tag, "_nonce"}, hasher_nonce, '0);
    checkOutput({tag, "_valid"}, golden_valid, '0);
    checkOutput({tag, "_gnonce"}, golden_nonce, '0);
    checkOutput({tag, "_hashing"}, hashing, '0);
    checkOutput({tag, "_ovf"}, fifo_overflow, '0);
`ifdef GOLDEN_DROP_CNT_EN
    checkOutput({tag, "_drop"}, drop_count, '0);
`endif
  endtask

  logic [31:0] r_frz;
  logic [31:0] force_val;
  logic [31:0] first_exp;

  initial begin
    hash_rst_n = 1'b0;
    tick(); tick();
    checkZeroOutputs("reset");
    hash_rst_n = 1'b1;
    tick();

    // Work change, counters start, ignore window masks results.
    $display("[TB] new work and ignore window");
    work_midstate = 256'h1;
    tick();
    tick();
    checkOutput("t1_hashing", hashing, 1'b1);
    checkOutput("t1_nonce16", hasher_nonce, 32'd16);
    applyStimulus(4'b1111);
    tick();
    checkOutput("t1_nonce20", hasher_nonce, 32'd20);
    tick();
    checkOutput("t1_nonce24", hasher_nonce, 32'd24);
    tick(); tick();
    applyStimulus(4'b0000);
    tick(); tick(); tick();
    checkOutput("t1_no_valid", golden_valid, 1'b0);
    checkOutput("t1_no_ovf", fifo_overflow, 1'b0);

    // Single hit on core 2 at rpt_base 0x100.
    $display("[TB] single hit and pop");
    waitRpt(32'h100);
    applyStimulus(4'b0100);
    tick();
    applyStimulus(4'b0000);
    checkOutput("t2_not_yet", golden_valid, 1'b0);
    tick();
    checkOutput("t2_valid", golden_valid, 1'b1);
    checkOutput("t2_nonce", golden_nonce, 32'h102);
    golden_ready = 1'b1;
    tick();
    golden_ready = 1'b0;
    checkOutput("t2_popped", golden_valid, 1'b0);

    // Hits inside a window that gets reloaded by a further work change.
    $display("[TB] ignore window reload");
    work_midstate = 256'h2;
    tick(); tick();
    applyStimulus(4'b0010);
    tick();
    applyStimulus(4'b0000);
    work_midstate = 256'h3;
    tick(); tick(); tick(); tick();
    applyStimulus(4'b0010);
    tick();
    applyStimulus(4'b0000);
    tick(); tick(); tick(); tick();
    checkOutput("t3_masked", golden_valid, 1'b0);

    // Sweep end reached by pinning stop_base, then resume on new work.
    $display("[TB] sweep stop and resume");
    r_frz = m_rpt;
    force_val = r_frz + 32'd12;
    m_stop = force_val;
    force dut.stop_base = force_val;
    tick(); tick(); tick(); tick(); tick(); tick();
    checkOutput("t4_stopped", hashing, 1'b0);
    checkOutput("t4_frozen", hasher_nonce, r_frz + 32'd28);
    applyStimulus(4'b1111);
    tick(); tick();
    applyStimulus(4'b0000);
    tick(); tick();
    checkOutput("t4_ign_valid", golden_valid, 1'b0);
    checkOutput("t4_ign_ovf", fifo_overflow, 1'b0);
    work_midstate = 256'h4;
    tick();
    release dut.stop_base;
    tick();
    tick();
    checkOutput("t4_resume_nonce", hasher_nonce, r_frz + 32'd32);
    checkOutput("t4_resume_hashing", hashing, 1'b1);

    // Fill the FIFO past capacity, then a simultaneous push/pop while full.
    $display("[TB] fifo full behaviour");
    repeat (6) tick();
    first_exp = m_rpt;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(4'b0001);
      tick();
    end
    applyStimulus(4'b0000);
    tick(); tick(); tick();
    checkOutput("t5_valid", golden_valid, 1'b1);
    checkOutput("t5_head", golden_nonce, first_exp);
    checkOutput("t5_ovf", fifo_overflow, 1'b1);
`ifdef GOLDEN_DROP_CNT_EN
    checkOutput("t5_drop", drop_count, 16'd1);
`endif
    applyStimulus(4'b0001);
    tick();
    applyStimulus(4'b0000);
    golden_ready = 1'b1;
    tick();
    golden_ready = 1'b0;
    checkOutput("t5_pp_head", golden_nonce, first_exp + 32'd4);
`ifdef GOLDEN_DROP_CNT_EN
    checkOutput("t5_pp_drop", drop_count, 16'd1);
`endif
    golden_ready = 1'b1;
    repeat (8) tick();
    golden_ready = 1'b0;
    checkOutput("t5_drained", golden_valid, 1'b0);

    // Fresh run: two cores hit together, then reset mid-run.
    $display("[TB] multi hit and async reset");
    hash_rst_n = 1'b0;
    work_midstate = '0;
    tick(); tick();
    hash_rst_n = 1'b1;
    work_midstate = 256'h5;
    tick();
    checkOutput("t6_ovf_clear", fifo_overflow, 1'b0);
    waitRpt(32'h200);
    applyStimulus(4'b1010);
    tick();
    applyStimulus(4'b0000);
    tick();
    checkOutput("t6_valid", golden_valid, 1'b1);
    checkOutput("t6_nonce", golden_nonce, 32'h201);
    checkOutput("t6_ovf", fifo_overflow, 1'b1);
`ifdef GOLDEN_DROP_CNT_EN
    checkOutput("t6_drop", drop_count, 16'd1);
`endif
    tick(); tick();
    hash_rst_n = 1'b0;
    #1;
    checkZeroOutputs("midrun_reset");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
